pipeline_hazard_controller: RTL
===============================

Name: pipeline_hazard_controller

Overview:
- Sequences the decode stage and the pipeline around it: a register scoreboard drives RAW/WAW stalls, an FSM freezes the pipe during memory waits, and a counter asserts flushes after taken branches.
- Drives the `stall`/`flush` inputs of the fetch and decode stages.
- Tracks pending writes to the register bank via the writeback write port.

Parameters:
- NUM_REGS, 256, scoreboarded registers; indices >= NUM_REGS never stall.
- FLUSH_CYCLES, 2, cycles flush_id stays high after a taken branch (1..15).
- MEM_TIMEOUT, 1024, max MEM_WAIT cycles before abort (>=2).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  decode holds a real instruction
- id_reads  in  1  instruction reads r1/r2 (ADD, SUB, AND, WRL, RDL)
- id_writes  in  1  instruction writes rw
- id_r1  in  8  source index 1
- id_r2  in  8  source index 2
- id_rw  in  8  destination index
- wb_write_enable  in  1  writeback commits a register
- wb_rw  in  8  committed register index
- mem_req  in  1  one-cycle pulse: EX issued a memory access
- mem_ready  in  1  one-cycle pulse: memory access done
- branch_taken  in  1  one-cycle pulse from EX
- stall_if  out  1  hold fetch
- stall_id  out  1  hold decode
- stall_ex  out  1  hold execute and later stages
- flush_id  out  1  bubble decode output
- mem_error  out  1  sticky timeout flag
- busy_any  out  1  any scoreboard bit set

Behaviour:
- Reset (reset=0, async):
  - scoreboard cleared, FSM=RUN, counters 0.
  - All outputs 0 while reset is low.
- Scoreboard busy[NUM_REGS]:
  - issue = id_valid & ~stall_id & ~flush_id.
  - On issue with id_writes, set busy[id_rw] at the next edge.
  - On wb_write_enable, clear busy[wb_rw] at the next edge.
  - Same-edge set and clear of the same index: set wins.
  - Clears to an index that is not busy are ignored.
- hazard (combinational, from the current registered busy):
  - id_valid & ((id_reads & (busy[id_r1] | busy[id_r2])) | (id_writes & busy[id_rw])).
  - No same-cycle bypass: a register cleared this cycle still stalls this cycle and releases the next cycle.
- FSM states RUN, MEM_WAIT, FLUSH:
  - RUN:
    - mem_req & ~mem_ready -> MEM_WAIT, timer=0.
    - mem_req & mem_ready -> stay in RUN, no stall.
    - else branch_taken -> FLUSH, fcnt=FLUSH_CYCLES-1.
  - MEM_WAIT:
    - Timer increments each cycle.
    - mem_ready -> next state is FLUSH if a branch is pending (pend_br), else RUN.
    - timer==MEM_TIMEOUT-1 without mem_ready -> mem_error=1 (sticky until reset), exit as if mem_ready.
    - branch_taken while in MEM_WAIT sets pend_br; pend_br is cleared on entry to FLUSH.
  - FLUSH:
    - fcnt decrements each cycle; fcnt==0 -> RUN.
    - branch_taken reloads fcnt=FLUSH_CYCLES-1.
    - mem_req -> MEM_WAIT; the remaining flush is then owed via pend_br.
- Outputs (combinational from state and inputs):
  - stall_ex = (state==MEM_WAIT & ~mem_ready) | (state==RUN & mem_req & ~mem_ready).
  - flush_id = (state==FLUSH) | (state==RUN & branch_taken & ~stall_ex).
  - stall_id = stall_ex | (hazard & ~flush_id).
  - stall_if = stall_id.
  - busy_any = |busy.
- Flush overrides hazard stalls: the bubbled instruction never issues.
- Mid-operation reset aborts MEM_WAIT/FLUSH immediately.

Optional Feature:
- HAZARD_STATS_EN defined:
  - Adds outputs stat_raw, stat_mem, stat_flush (32 bits each, saturating).
  - stat_raw counts cycles with hazard & ~flush_id.
  - stat_mem counts cycles with stall_ex.
  - stat_flush counts flush_id cycles.
  - All reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Issue writer rw=5, then reader r1=5 next cycle; wb_write_enable,wb_rw=5 at cycle 4 -> stall_id high cycles 1-4, low cycle 5, reader issues cycle 5.
- Writer rw=7 issues while wb_rw=7 clears in the same cycle -> busy[7] remains 1, busy_any=1.
- mem_req pulse at cycle 0, mem_ready at cycle 6 -> stall_ex high cycles 0-5, low cycle 6, FSM back to RUN at cycle 7.
- branch_taken at cycle 0, FLUSH_CYCLES=2 -> flush_id high cycles 0-2; a hazard present in those cycles yields stall_id=0.
- branch_taken during MEM_WAIT, mem_ready at cycle 4 -> flush_id low until cycle 5, high cycles 5-6, then RUN.
- MEM_TIMEOUT=8, no mem_ready -> mem_error=1 after 8 wait cycles, stall_ex drops; async reset mid-MEM_WAIT clears all outputs immediately.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - decode-stage hazard scoreboard, memory-wait and branch-flush sequencer
// Optional per-cause stall/flush counters are compiled in with HAZARD_STATS_EN.
module pipeline_hazard_controller #(
    parameter int NUM_REGS     = 256,
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_valid,
    input  logic        id_reads,
    input  logic        id_writes,
    input  logic [7:0]  id_r1,
    input  logic [7:0]  id_r2,
    input  logic [7:0]  id_rw,
    input  logic        wb_write_enable,
    input  logic [7:0]  wb_rw,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        flush_id,
    output logic        mem_error,
    output logic        busy_any
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stat_raw,
    output logic [31:0] stat_mem,
    output logic [31:0] stat_flush
`endif
);

    localparam int TW = $clog2(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_FLUSH    = 2'd2
    } state_t;

    state_t                state, state_n;
    logic [TW-1:0]         timer, timer_n;
    logic [3:0]            fcnt, fcnt_n;
    logic                  pend_br, pend_br_n;
    logic                  mem_error_n;
    logic [NUM_REGS-1:0]   busy;

    logic hazard;
    logic issue;
    logic stall_ex_c, flush_c, stall_id_c;

    // Registers past NUM_REGS have no scoreboard bit and read as not busy.
    function automatic logic busy_at(input logic [NUM_REGS-1:0] vec, input logic [7:0] idx);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == 8'(i)) begin
                r = vec[i];
            end
        end
        return r;
    endfunction

    always_comb begin
        hazard = reset & id_valid &
                 ((id_reads & (busy_at(busy, id_r1) | busy_at(busy, id_r2))) |
                  (id_writes & busy_at(busy, id_rw)));
    end

    // Output process: every combinational output is forced low while reset is held.
    always_comb begin
        stall_ex_c = reset & (((state == S_MEM_WAIT) & ~mem_ready) |
                              ((state == S_RUN) & mem_req & ~mem_ready));
        flush_c    = reset & ((state == S_FLUSH) |
                              ((state == S_RUN) & branch_taken & ~stall_ex_c));
        stall_id_c = stall_ex_c | (hazard & ~flush_c);
        issue      = id_valid & ~stall_id_c & ~flush_c;
    end

    assign stall_ex = stall_ex_c;
    assign flush_id = flush_c;
    assign stall_id = stall_id_c;
    assign stall_if = stall_id_c;
    assign busy_any = |busy;

    // Next-state process.
    always_comb begin
        state_n     = state;
        timer_n     = timer;
        fcnt_n      = fcnt;
        pend_br_n   = pend_br;
        mem_error_n = mem_error;
        case (state)
            S_RUN: begin
                if (mem_req & ~mem_ready) begin
                    state_n   = S_MEM_WAIT;
                    timer_n   = '0;
                    pend_br_n = branch_taken;
                end else if (branch_taken) begin
                    state_n = S_FLUSH;
                    fcnt_n  = 4'(FLUSH_CYCLES - 1);
                end
            end
            S_MEM_WAIT: begin
                timer_n = timer + 1'b1;
                if (mem_ready | (timer == TW'(MEM_TIMEOUT - 1))) begin
                    if (~mem_ready) begin
                        mem_error_n = 1'b1;
                    end
                    pend_br_n = 1'b0;
                    if (pend_br | branch_taken) begin
                        state_n = S_FLUSH;
                        fcnt_n  = 4'(FLUSH_CYCLES - 1);
                    end else begin
                        state_n = S_RUN;
                    end
                end else if (branch_taken) begin
                    pend_br_n = 1'b1;
                end
            end
            S_FLUSH: begin
                if (mem_req & ~mem_ready) begin
                    state_n   = S_MEM_WAIT;
                    timer_n   = '0;
                    pend_br_n = 1'b1;
                end else if (branch_taken) begin
                    fcnt_n = 4'(FLUSH_CYCLES - 1);
                end else if (fcnt == 4'd0) begin
                    state_n = S_RUN;
                end else begin
                    fcnt_n = fcnt - 4'd1;
                end
            end
            default: begin
                state_n = S_RUN;
            end
        endcase
    end

    // State register process.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_RUN;
            timer     <= '0;
            fcnt      <= '0;
            pend_br   <= 1'b0;
            mem_error <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            fcnt      <= fcnt_n;
            pend_br   <= pend_br_n;
            mem_error <= mem_error_n;
        end
    end

    // A set and a clear of the same register on one edge leaves it busy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (issue && id_writes && (id_rw == 8'(i))) begin
                    busy[i] <= 1'b1;
                end else if (wb_write_enable && (wb_rw == 8'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_raw   <= '0;
            stat_mem   <= '0;
            stat_flush <= '0;
        end else begin
            if (hazard && !flush_c && (stat_raw != '1)) begin
                stat_raw <= stat_raw + 32'd1;
            end
            if (stall_ex_c && (stat_mem != '1)) begin
                stat_mem <= stat_mem + 32'd1;
            end
            if (flush_c && (stat_flush != '1)) begin
                stat_flush <= stat_flush + 32'd1;
            end
        end
    end
`endif

endmodule
